mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum WAIT-state cycles before the transaction aborts; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  requester has a transaction.
REQ-005 req_ready  output  1  controller accepts a transaction this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  16  transaction address.
REQ-008 req_wdata  input  16  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  requester consumes the response.
REQ-011 rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  transaction timed out.
REQ-013 bus_out  output  16  value driven to the device bus input.
REQ-014 ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en  output  1 each  device strobes; r_w: 1 = write, 0 = read.
REQ-015 mdr_in  input  16  device MDR output; valid only while gate_mdr_en=1.
REQ-016 mem_ready  input  1  device ready, registered inside the device.

Function
REQ-017 The FSM SHALL have the states IDLE, MAR, MDR_W, ACCESS, WAIT, GATE and RESP; all strobes SHALL be Moore-decoded from the state and the latched request.
REQ-018 req_ready SHALL be 1 only in IDLE; req_valid&&req_ready SHALL latch addr/wdata/we and move to MAR.
REQ-019 MAR: ld_mar=1, bus_out=addr; next state is MDR_W if we=1, else ACCESS.
REQ-020 MDR_W: ld_mdr=1, mio_en=0, bus_out=wdata; next state is ACCESS.
REQ-021 ACCESS: mio_en=1, r_w=we, ld_mdr=~we, bus_out=0; next state is WAIT, with the timeout counter cleared.
REQ-022 WAIT: all strobes 0; mem_ready=1 -> GATE (read) or RESP (write, rsp_err=0); otherwise the counter increments.
REQ-023 In WAIT, if the counter reaches TIMEOUT_CYC-1 with mem_ready=0, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-024 GATE: gate_mdr_en=1 for exactly one cycle; rsp_rdata SHALL capture mdr_in at the end of that cycle; next state is RESP.
REQ-025 RESP: rsp_valid=1, and rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; then the FSM returns to IDLE with rsp_valid=0 the next cycle.
REQ-026 bus_out SHALL be 0 in every state other than MAR and MDR_W; gate_mdr_en SHALL be 0 outside GATE.
REQ-027 Minimum latency from acceptance to rsp_valid: read 4 cycles (MAR, ACCESS, WAIT, GATE); write 4 cycles (MAR, MDR_W, ACCESS, WAIT).
REQ-028 A request presented while req_ready=0 SHALL be ignored; no queueing.
REQ-029 A mem_ready value seen outside WAIT SHALL have no effect.
REQ-030 Back-to-back transactions: rsp_ready=1 on the first RESP cycle plus req_valid=1 SHALL give acceptance one cycle later in IDLE.
REQ-031 The counter SHALL saturate and never wrap; the counter width is 8 bits.

Reset
REQ-032 While rst=1, state SHALL be IDLE and rsp_rdata, rsp_err, latched request and counter SHALL be 0.
REQ-033 While rst=1, rsp_valid, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en and bus_out SHALL be 0, and req_ready SHALL be 1 once rst deasserts.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately with no response; the first post-reset request SHALL execute normally.

Verification
REQ-035 Write 16'h3000 <- 16'hBEEF, mem_ready high -> ld_mar with bus_out=3000, then ld_mdr with bus_out=BEEF, then mio_en=1 and r_w=1 for 1 cycle, then rsp_valid with err=0.
REQ-036 Read 16'h3000 after that write, with a device model -> ld_mdr=1 and mio_en=1 in ACCESS, gate_mdr_en for 1 cycle, rsp_rdata=16'hBEEF.
REQ-037 mem_ready held 0, TIMEOUT_CYC=16 -> exactly 16 WAIT cycles, then rsp_err=1, rsp_rdata=0; the next request is accepted normally.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and req_ready=0 stable for all 5 cycles.
REQ-039 rst pulsed during WAIT of a write to 16'hFE06 -> all strobes 0 while rst=1, no rsp_valid; a read of 16'hFE04 afterwards completes.
REQ-040 Back-to-back read 16'h0100 then write 16'h0101 with rsp_ready tied 1 -> second acceptance exactly 1 cycle after the first RESP.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between a requester and the memory access controller.
// The requester drives the master side; the controller uses the slave side.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one memory transaction at a time through MAR/MDR device strobes,
// with a WAIT-state timeout that turns a stuck device into an error response.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus,
    output logic [15:0]        bus_out,
    output logic               ld_mar,
    output logic               ld_mdr,
    output logic               mio_en,
    output logic               r_w,
    output logic               gate_mdr_en,
    input  logic [15:0]        mdr_in,
    input  logic               mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        MAR,
        MDR_W,
        ACCESS,
        WAIT,
        GATE,
        RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [7:0]  wait_cnt;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        timed_out;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign timed_out = (state == WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                we_q    <= bus.req_we;
            end

            if (state == ACCESS) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !mem_ready && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (state == WAIT) begin
                if (mem_ready) begin
                    if (we_q) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end else if (timed_out) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end

            if (state == GATE) begin
                rdata_q <= mdr_in;
                err_q   <= 1'b0;
            end
        end
    end

    // Next state and Moore-decoded strobes
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus_out       = '0;
        ld_mar        = 1'b0;
        ld_mdr        = 1'b0;
        mio_en        = 1'b0;
        r_w           = 1'b0;
        gate_mdr_en   = 1'b0;

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = MAR;
                end
            end
            MAR: begin
                ld_mar     = 1'b1;
                bus_out    = addr_q;
                next_state = we_q ? MDR_W : ACCESS;
            end
            MDR_W: begin
                ld_mdr     = 1'b1;
                bus_out    = wdata_q;
                next_state = ACCESS;
            end
            ACCESS: begin
                mio_en     = 1'b1;
                r_w        = we_q;
                ld_mdr     = ~we_q;
                next_state = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    next_state = we_q ? RESP : GATE;
                end else if (timed_out) begin
                    next_state = RESP;
                end
            end
            GATE: begin
                gate_mdr_en = 1'b1;
                next_state  = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a small MAR/MDR device model plus a response
// scoreboard fed at request acceptance and drained at each response handshake.
module tb_mem_access_ctrl;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] bus_out;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic        gate_mdr_en;
    logic [15:0] mdr_in;
    logic        mem_ready;

    logic        ready_en;
    logic [15:0] dev_mar;
    logic [15:0] dev_mdr;
    logic [15:0] mem [0:65535];

    exp_t sb[$];
    int   checks;
    int   errors;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .bus_out     (bus_out),
        .ld_mar      (ld_mar),
        .ld_mdr      (ld_mdr),
        .mio_en      (mio_en),
        .r_w         (r_w),
        .gate_mdr_en (gate_mdr_en),
        .mdr_in      (mdr_in),
        .mem_ready   (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device: MAR/MDR registers, memory array, and a registered ready flag
    always @(posedge clk) begin
        if (rst) begin
            mem[16'hFE04] <= 16'h5A5A;
            mem[16'h0100] <= 16'h1111;
        end
        if (ld_mar) dev_mar <= bus_out;
        if (ld_mdr) dev_mdr <= mio_en ? mem[dev_mar] : bus_out;
        if (mio_en && r_w) mem[dev_mar] <= dev_mdr;
        mem_ready <= mio_en && ready_en;
    end

    assign mdr_in = gate_mdr_en ? dev_mdr : 16'hDEAD;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [15:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Scoreboard drain on every response handshake
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
                checkOutput("rsp_err", bus.rsp_err, e.err);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] exp_rdata, input logic exp_err,
                                 input int exp_wait, input int hold);
        int n;
        logic [15:0] held;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("idle_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        pushExp(exp_rdata, exp_err);
        bus.req_valid = 1'b0;
        checkOutput("mar_ld", {ld_mar, ld_mdr, mio_en, gate_mdr_en}, 4'b1000);
        checkOutput("mar_bus", bus_out, addr);
        checkOutput("mar_req_ready", bus.req_ready, 0);
        tick();
        if (we) begin
            checkOutput("mdrw_strb", {ld_mar, ld_mdr, mio_en, gate_mdr_en}, 4'b0100);
            checkOutput("mdrw_bus", bus_out, wdata);
            tick();
        end
        checkOutput("access_strb", {ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en}, {1'b0, ~we, 1'b1, we, 1'b0});
        checkOutput("access_bus", bus_out, 0);
        tick();
        n = 0;
        while (!gate_mdr_en && !bus.rsp_valid && n < 300) begin
            checkOutput("wait_strb", {ld_mar, ld_mdr, mio_en, r_w, bus_out}, 0);
            n++;
            tick();
        end
        checkOutput("wait_cycles", n, exp_wait);
        if (!we && !exp_err) begin
            checkOutput("gate_en", gate_mdr_en, 1);
            checkOutput("gate_bus", bus_out, 0);
            tick();
            checkOutput("gate_one_cycle", gate_mdr_en, 0);
        end
        checkOutput("resp_valid", bus.rsp_valid, 1);
        held = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("resp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata}, {1'b1, 1'b0, held});
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("resp_done", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int cyc;
        int rsp_cyc;
        int acc_cyc;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        ready_en      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_strb", {ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_out}, 0);
        checkOutput("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_req_ready", bus.req_ready, 1);

        $display("[TB] write 3000 <- BEEF");
        applyStimulus(1'b1, 16'h3000, 16'hBEEF, 16'h0000, 1'b0, 1, 0);
        $display("[TB] read 3000");
        applyStimulus(1'b0, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, 1, 0);

        $display("[TB] timeout read");
        ready_en = 1'b0;
        applyStimulus(1'b0, 16'h3000, 16'h0000, 16'h0000, 1'b1, 16, 0);
        ready_en = 1'b1;

        $display("[TB] read with 5-cycle response stall");
        applyStimulus(1'b0, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, 1, 5);

        $display("[TB] reset during WAIT of write FE06");
        ready_en      = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'hFE06;
        bus.req_wdata = 16'h7777;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_strb", {ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_out}, 0);
        checkOutput("rst_mid_rsp_valid", bus.rsp_valid, 0);
        tick();
        checkOutput("rst_mid_hold", {bus.rsp_valid, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_out}, 0);
        rst      = 1'b0;
        ready_en = 1'b1;
        tick();
        checkOutput("rst_mid_req_ready", bus.req_ready, 1);
        applyStimulus(1'b0, 16'hFE04, 16'h0000, 16'h5A5A, 1'b0, 1, 0);

        $display("[TB] back-to-back read 0100 then write 0101");
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0100;
        tick();
        pushExp(16'h1111, 1'b0);
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0101;
        bus.req_wdata = 16'hCAFE;
        cyc     = 0;
        rsp_cyc = -1;
        acc_cyc = -1;
        while (acc_cyc < 0 && cyc < 50) begin
            if (bus.rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
            if (bus.req_ready) begin
                acc_cyc = cyc;
            end else begin
                tick();
                cyc++;
            end
        end
        checkOutput("b2b_gap", acc_cyc - rsp_cyc, 1);
        pushExp(16'h0000, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("b2b_mar", {ld_mar, bus_out}, {1'b1, 16'h0101});
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        checkOutput("b2b_write_rsp", bus.rsp_valid, 1);
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("b2b_mem_written", mem[16'h0101], 16'hCAFE);
        checkOutput("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
